// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the uart byte receiver
//
// Contents:
//   rx_state_e     receiver state encoding
//   DATA_BITS      data bits per frame
//   clk_cnt_width  bit-clock counter width for a given clocks-per-bit
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5,
    BREAK  = 3'd6
  } rx_state_e;

  // The counter only ever has to hold values up to cpb-1.
  function automatic int clk_cnt_width(input int cpb);
    return (cpb <= 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop synchronizer for the asynchronous rx line
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset; both flops reset to 1 (idle line)
//   d_i   asynchronous input
//   q_o   synchronized output
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - oversampling 8N1 serial byte receiver with strobe output
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rst        synchronous active-high reset
//   rx_data    asynchronous serial line, idles high
//   rd_cmd     one-cycle pulse when a valid byte is received
//   rcv_data   last valid byte, held until the next valid byte
//   frame_err  one-cycle pulse when a frame is rejected
//
// Optional feature: define UART_RX_PARITY_CHECK_EN to expect an even parity
// bit between the data bits and the stop bit.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic       rd_cmd,
  output logic [7:0] rcv_data,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW           = clk_cnt_width(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_byte_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic rx_s;

  rx_sync u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_data),
    .q_o (rx_s)
  );

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  rd_q, rd_d;
  logic                  ferr_q, ferr_d;
  logic                  frame_ok;
`ifdef UART_RX_PARITY_CHECK_EN
  logic                  par_err_q, par_err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= 8'h00;
      rd_q    <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_CHECK_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // A frame is accepted only if the stop bit is high (and parity matched).
`ifdef UART_RX_PARITY_CHECK_EN
  assign frame_ok = rx_s & ~par_err_q;
`else
  assign frame_ok = rx_s;
`endif

  // The strobes are registered on the transition into DONE/BREAK so that they
  // and the updated rcv_data are all visible during the DONE/BREAK cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rd_d    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // Re-check the line at mid start bit to reject glitches.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          bit_d          = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_CHECK_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_err_d = ^{shift_q, rx_s};
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (frame_ok) begin
            state_d = DONE;
            rd_d    = 1'b1;
            data_d  = shift_q;
          end else begin
            state_d = BREAK;
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      BREAK: begin
        // Stay until the line is released so a held-low line is not
        // mistaken for a stream of start bits.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_cmd    = rd_q;
  assign frame_err = ferr_q;
  assign rcv_data  = data_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - self-checking bench for uart_byte_rx
module tb_uart_byte_rx;

  localparam int BIT_CLKS = 10;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Mid-stop sample plus synchronizer and strobe register delay.
  localparam int LAT = (FRAME_BITS - 1) * BIT_CLKS + BIT_CLKS / 2 + 3;
  localparam int TOL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_data = 1'b1;
  logic       rd_cmd;
  logic [7:0] rcv_data;
  logic       frame_err;

  uart_byte_rx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rd_cmd    (rd_cmd),
    .rcv_data  (rcv_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         good;
    logic [7:0] data;
    int         due;
  } ev_t;

  ev_t        exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] hold = 8'h00;
  int         n_rd = 0;
  int         n_fe = 0;
  int         rd_cyc[$];
  bit         prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: each sent frame becomes one expected strobe at a known time.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        hold = 8'h00;
        exp_q.delete();
      end
      check("rd_fe_exclusive", {31'd0, rd_cmd & frame_err}, 32'd0);
      if (rd_cmd || frame_err) begin
        check("single_cycle_strobe", {31'd0, prev_strobe}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: rd_cmd=%0b frame_err=%0b, required none (cycle %0d)",
                   rd_cmd, frame_err, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_rd_cmd", {31'd0, rd_cmd}, {31'd0, e.good});
          tests++;
          if (cyc < e.due - TOL || cyc > e.due + TOL) begin
            fails++;
            $display("FAIL strobe_time: got cycle %0d, required %0d +/- %0d", cyc, e.due, TOL);
          end
          if (rd_cmd) begin
            hold = e.data;
            n_rd++;
            rd_cyc.push_back(cyc);
          end else begin
            n_fe++;
          end
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due + TOL) begin
        tests++;
        fails++;
        $display("FAIL missing_strobe: got none by cycle %0d, required near %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      check("rcv_data_hold", {24'd0, rcv_data}, {24'd0, hold});
      prev_strobe = rd_cmd | frame_err;
    end
  end

  task automatic drive_bit(input logic v);
    rx_data = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Starts and ends on a negedge; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    ev_t e;
    e.good = stop_ok && par_ok;
    e.data = d;
    e.due  = cyc + LAT;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_CHECK_EN
    drive_bit((^d) ^ ~par_ok);
`endif
    drive_bit(stop_ok);
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'h3C;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("reset_rcv_data", {24'd0, rcv_data}, 32'h00);
    check("reset_rd_cmd", {31'd0, rd_cmd}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;

    // Single byte after idle.
    idle(50);
    send_frame(8'h55, 1'b1, 1'b1);
    idle(20);
    check("pin_first_byte", {24'd0, rcv_data}, 32'h55);

    // Back-to-back frames, no idle gap.
    send_frame(8'h10, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    idle(20);
    check("pin_b2b_second", {24'd0, rcv_data}, 32'hF0);
    check("b2b_gap_ok", {31'd0, (rd_cyc[2] - rd_cyc[1] >= FRAME_BITS * BIT_CLKS - 1) &&
                                (rd_cyc[2] - rd_cyc[1] <= FRAME_BITS * BIT_CLKS + 1)}, 32'd1);

    // Glitch shorter than half a bit.
    rx_data = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    send_frame(8'h09, 1'b1, 1'b1);
    idle(20);
    check("pin_after_glitch", {24'd0, rcv_data}, 32'h09);

    // Framing error with a line held low.
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hA3, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    idle(20);
    check("pin_break_keeps", {24'd0, rcv_data}, 32'h55);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(20);
    check("pin_after_break", {24'd0, rcv_data}, 32'h01);

    // Reset after the 4th data bit aborts the frame.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i]);
    rst = 1'b1;
    rx_data = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("pin_reset_clears", {24'd0, rcv_data}, 32'h00);
    idle(150);
    check("pin_no_strobe_after_abort", {24'd0, rcv_data}, 32'h00);
    send_frame(8'h40, 1'b1, 1'b1);
    idle(20);
    check("pin_after_reset", {24'd0, rcv_data}, 32'h40);

`ifdef UART_RX_PARITY_CHECK_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("pin_parity_good", {24'd0, rcv_data}, 32'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("pin_parity_bad_keeps", {24'd0, rcv_data}, 32'h07);
    check("total_rd_cmd", n_rd, 32'd8);
    check("total_frame_err", n_fe, 32'd2);
`else
    check("total_rd_cmd", n_rd, 32'd7);
    check("total_frame_err", n_fe, 32'd1);
`endif

    idle(150);
    check("all_strobes_seen", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
